// File: rtl/dap_rx_scheduler.sv
// DAP receive packet scheduler: frames the OUT byte stream into PKT_LEN-byte packets and routes
// each to the transfer or general engine under a credit limit. DAP_SCHED_ABORT_EN adds abort discard.
module dap_rx_scheduler #(
  parameter int unsigned PKT_LEN         = 512,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [7:0]  ABORT_CMD       = 8'h07
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] xfer_tdata,
  output logic       xfer_tvalid,
  output logic       xfer_tlast,
  input  logic       xfer_tready,
  output logic [7:0] gen_tdata,
  output logic       gen_tvalid,
  output logic       gen_tlast,
  input  logic       gen_tready,
  input  logic       rsp_done,
  output logic       abort,
  output logic [3:0] outstanding,
  output logic       busy,
  output logic       credit_err
);

  localparam int unsigned   CW        = $clog2(PKT_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);
  localparam logic [3:0]    MAX_OUT   = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GEN  = 2'd2
`ifdef DAP_SCHED_ABORT_EN
    , DISCARD = 2'd3
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          hs;
  logic          route;
  logic          last_beat;
  logic          credit_ok;
  logic          head_xfer;

  assign last_beat = (cnt == LAST_BEAT);
  assign credit_ok = (outstanding < MAX_OUT);
  assign head_xfer = (s_axis_tdata inside {8'h05, 8'h06, 8'h14, 8'h1D});

  // Data lanes are pure wires; only the valids select the destination.
  assign xfer_tdata = s_axis_tdata;
  assign gen_tdata  = s_axis_tdata;

`ifdef DAP_SCHED_ABORT_EN
  logic abort_det;
  logic abort_q;
  assign abort = abort_q;
`else
  logic unused_abort_cmd;
  assign unused_abort_cmd = ^ABORT_CMD;
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    xfer_tvalid   = 1'b0;
    xfer_tlast    = 1'b0;
    gen_tvalid    = 1'b0;
    gen_tlast     = 1'b0;
    hs            = 1'b0;
    route         = 1'b0;
`ifdef DAP_SCHED_ABORT_EN
    abort_det     = 1'b0;
`endif
    case (state)
      IDLE: begin
        // Head byte is only peeked here; it is consumed as beat 0 in the next state.
        if (s_axis_tvalid) begin
`ifdef DAP_SCHED_ABORT_EN
          if (s_axis_tdata == ABORT_CMD) begin
            abort_det = 1'b1;
            state_nxt = DISCARD;
          end else
`endif
          if (credit_ok) begin
            route     = 1'b1;
            state_nxt = head_xfer ? XFER : GEN;
          end
        end
      end
      XFER: begin
        xfer_tvalid   = s_axis_tvalid;
        xfer_tlast    = last_beat;
        s_axis_tready = xfer_tready;
        hs            = s_axis_tvalid & xfer_tready;
        if (hs && last_beat) state_nxt = IDLE;
      end
      GEN: begin
        gen_tvalid    = s_axis_tvalid;
        gen_tlast     = last_beat;
        s_axis_tready = gen_tready;
        hs            = s_axis_tvalid & gen_tready;
        if (hs && last_beat) state_nxt = IDLE;
      end
`ifdef DAP_SCHED_ABORT_EN
      DISCARD: begin
        s_axis_tready = 1'b1;
        hs            = s_axis_tvalid;
        if (hs && last_beat) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      outstanding <= '0;
      credit_err  <= 1'b0;
      busy        <= 1'b0;
`ifdef DAP_SCHED_ABORT_EN
      abort_q     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
`ifdef DAP_SCHED_ABORT_EN
      abort_q <= abort_det;
`endif
      if (state == IDLE)
        cnt <= '0;
      else if (hs)
        cnt <= cnt + CW'(1);
      // A route and a returned credit in the same cycle cancel out.
      case ({route, rsp_done})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   if (outstanding != 4'd0) outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
      if (rsp_done && outstanding == 4'd0) credit_err <= 1'b1;
    end
  end

endmodule

// File: doc/dap_rx_scheduler.md
# dap_rx_scheduler

Packet scheduler between the DAP OUT-endpoint byte FIFO and the command engines. Frames the receive byte stream into fixed-length DAP packets, peeks each packet's command byte, and routes the packet to either the transfer engine or the general command handler. Limits the number of packets in flight to a credit count returned by the response path. With abort support compiled in, it discards DAP_TransferAbort packets and raises an abort pulse.

## Interface
Parameters:
- `PKT_LEN`, default 512: bytes per DAP packet; power of two, at least 2.
- `MAX_OUTSTANDING`, default 4: packets routed but not yet answered; range 1..15.
- `ABORT_CMD`, default 8'h07: DAP_TransferAbort command ID.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  8  byte from the receive FIFO; stable while `s_axis_tvalid` is high.
- `s_axis_tvalid`  in  1  receive FIFO not empty.
- `s_axis_tready`  out  1  consume the current byte.
- `xfer_tdata` / `xfer_tvalid` / `xfer_tlast`  out  8/1/1  transfer-engine stream.
- `xfer_tready`  in  1  transfer engine accepts.
- `gen_tdata` / `gen_tvalid` / `gen_tlast`  out  8/1/1  general-command stream.
- `gen_tready`  in  1  general handler accepts.
- `rsp_done`  in  1  one-cycle pulse per response completed; returns one credit.
- `abort`  out  1  one-cycle pulse when an abort packet head is detected.
- `outstanding`  out  4  packets in flight.
- `busy`  out  1  high when the state is not IDLE.
- `credit_err`  out  1  sticky flag: `rsp_done` arrived while `outstanding` was 0.

## Operation
- FSM states: IDLE, XFER, GEN, DISCARD. Byte counter width is $clog2(PKT_LEN).
- IDLE:
  - `s_axis_tready` is 0 and no byte is consumed; the head byte is only peeked.
  - Counter is cleared.
  - When `s_axis_tvalid` is high:
    - If `s_axis_tdata` equals ABORT_CMD (abort enabled): pulse `abort` and go to DISCARD. This ignores credits.
    - Otherwise, if `outstanding` < MAX_OUTSTANDING: go to XFER when the command is in {8'h05, 8'h06, 8'h14, 8'h1D}, else go to GEN. `outstanding` increments in this same cycle.
    - Otherwise: stay in IDLE (credit stall).
- XFER and GEN: combinational pass-through.
  - The selected port's tdata follows `s_axis_tdata`, its tvalid follows `s_axis_tvalid`, and `s_axis_tready` follows the selected tready.
  - The unselected port's tvalid is 0.
  - tlast = (counter == PKT_LEN-1).
  - Counter increments on each handshake. The last-beat handshake returns the FSM to IDLE.
- DISCARD: `s_axis_tready` = 1. Count valid beats; after beat PKT_LEN-1, return to IDLE. No output valid is asserted.
- Credits: increment and `rsp_done` in the same cycle leave `outstanding` unchanged. `rsp_done` at 0 keeps the count at 0 and sets `credit_err`.
- Counter arithmetic wraps naturally at PKT_LEN; no terminal overflow state.

## Timing
- Reset values: state IDLE, counter 0, `outstanding` 0, `abort` 0, `busy` 0, `credit_err` 0, all tvalid/tlast 0, `s_axis_tready` 0.
- Reset mid-packet: state returns to IDLE and credits are cleared. The upstream FIFO is reset in the same cycle.
- Head decision: one IDLE cycle per packet. Packet byte 0 transfers at the earliest one cycle after tvalid rises.
- Streaming latency: zero cycles. Full-rate throughput is PKT_LEN+1 cycles per packet.
- `abort` is asserted in the IDLE→DISCARD cycle only; it is registered, so it is visible the cycle after detection.
- A stall on either tready freezes the counter and state. tdata is not held internally; the source keeps it stable.
- `busy` and `outstanding` are registered outputs.

## Configuration
- `DAP_SCHED_ABORT_EN` defined: ABORT_CMD detection, DISCARD state, and the `abort` pulse are present.
- Not defined: no DISCARD state and `abort` is tied 0. ABORT_CMD is treated as an ordinary command, so it routes to GEN and consumes a credit.

## Test plan
- PKT_LEN=8; packet with head 8'h05 and 8 bytes, `xfer_tready`=1 → 8 beats on xfer, `xfer_tlast` on beat 7, `gen_tvalid` stays 0, `outstanding`=1.
- Head 8'h00, with `gen_tready` toggled every other cycle → all 8 bytes in order on gen, tlast on beat 7, no byte loss or duplication.
- MAX_OUTSTANDING=2; send 3 packets with no `rsp_done` → third head stalls in IDLE. One `rsp_done` pulse → third packet routes on the next cycle.
- With ABORT_EN and `outstanding`=MAX, head 8'h07 → `abort` high exactly 1 cycle, 8 bytes drained, `outstanding` unchanged, no output valid.
- `rsp_done` in the same cycle as a route decision → `outstanding` unchanged. `rsp_done` at 0 → `credit_err`=1 until `reset`.
- `reset` at beat 3 of an XFER packet → next cycle IDLE, `busy`=0, `outstanding`=0, `xfer_tvalid`=0.
